// File: rtl/pa_pmp_chk_arb.sv
// PMP check arbiter/sequencer: shares one combinational PMP check datapath
// between the IFU and LSU. Grants one check per cycle into a registered slot,
// splits granule-crossing LSU accesses into two back-to-back checks and
// returns a registered deny response to the owning requester.
module pa_pmp_chk_arb #(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              ifu_pmp_req,
  input  logic [ADDR_W-1:0] ifu_pmp_addr,
  input  logic              ifu_pmp_machine_mode,
  input  logic              lsu_pmp_req,
  input  logic [ADDR_W-1:0] lsu_pmp_addr,
  input  logic [ADDR_W-1:0] lsu_pmp_addr2,
  input  logic              lsu_pmp_cross,
  input  logic              lsu_pmp_write,
  input  logic              lsu_pmp_machine_mode,
  input  logic              csr_pmp_busy,
  input  logic              ifu_pmp_flush,
  input  logic              pmp_arb_deny,
  output logic              arb_pmp_chk_vld,
  output logic [ADDR_W-1:0] arb_pmp_chk_addr,
  output logic              arb_pmp_chk_src,
  output logic              arb_pmp_chk_write,
  output logic              arb_pmp_chk_mach_mode,
  output logic              pmp_ifu_grant,
  output logic              pmp_lsu_grant,
  output logic              pmp_ifu_rsp_vld,
  output logic              pmp_ifu_rsp_deny,
  output logic              pmp_lsu_rsp_vld,
  output logic              pmp_lsu_rsp_deny
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t            state_reg;
  logic [3:0]        starve_cnt_reg;
  logic [ADDR_W-1:0] addr2_reg;
  logic              chk_first_reg;   // slot holds first half of a cross split
  logic              chk_second_reg;  // slot holds second half of a cross split
  logic              sticky_deny_reg;

  logic grant_ok;
  logic ifu_prio;
  logic ifu_rsp_vld_next;
  logic lsu_rsp_vld_next;

  // Grant decision: LSU by default, IFU once it has starved long enough.
  always_comb begin
    grant_ok      = (state_reg == IDLE) && !csr_pmp_busy && !cpurst;
    ifu_prio      = ifu_pmp_req && (!lsu_pmp_req || (starve_cnt_reg == STARVE_LIM));
    pmp_ifu_grant = grant_ok && ifu_prio;
    pmp_lsu_grant = grant_ok && lsu_pmp_req && !ifu_prio;
  end

  // Response qualification; a flush kills an IFU check currently in the slot.
  always_comb begin
    ifu_rsp_vld_next = arb_pmp_chk_vld && !arb_pmp_chk_src && !ifu_pmp_flush;
    lsu_rsp_vld_next = arb_pmp_chk_vld && arb_pmp_chk_src && !chk_first_reg;
  end

  // Sequencer state, starvation counter, check slot and responses.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_reg             <= IDLE;
      starve_cnt_reg        <= '0;
      addr2_reg             <= '0;
      chk_first_reg         <= 1'b0;
      chk_second_reg        <= 1'b0;
      sticky_deny_reg       <= 1'b0;
      arb_pmp_chk_vld       <= 1'b0;
      arb_pmp_chk_addr      <= '0;
      arb_pmp_chk_src       <= 1'b0;
      arb_pmp_chk_write     <= 1'b0;
      arb_pmp_chk_mach_mode <= 1'b0;
      pmp_ifu_rsp_vld       <= 1'b0;
      pmp_ifu_rsp_deny      <= 1'b0;
      pmp_lsu_rsp_vld       <= 1'b0;
      pmp_lsu_rsp_deny      <= 1'b0;
    end else begin
      // SECOND lasts exactly one cycle: the first half is being checked.
      state_reg <= (pmp_lsu_grant && lsu_pmp_cross) ? SECOND : IDLE;

      // Starvation only advances in cycles where a grant could be made.
      if (!ifu_pmp_req || pmp_ifu_grant) begin
        starve_cnt_reg <= '0;
      end else if (grant_ok && (starve_cnt_reg != STARVE_LIM)) begin
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
      end

      if (state_reg == SECOND) begin
        // Second half of the split; write/mode stay from the first half.
        arb_pmp_chk_vld  <= 1'b1;
        arb_pmp_chk_addr <= addr2_reg;
        arb_pmp_chk_src  <= 1'b1;
        chk_first_reg    <= 1'b0;
        chk_second_reg   <= 1'b1;
      end else if (pmp_ifu_grant) begin
        arb_pmp_chk_vld       <= 1'b1;
        arb_pmp_chk_addr      <= ifu_pmp_addr;
        arb_pmp_chk_src       <= 1'b0;
        arb_pmp_chk_write     <= 1'b0;
        arb_pmp_chk_mach_mode <= ifu_pmp_machine_mode;
        chk_first_reg         <= 1'b0;
        chk_second_reg        <= 1'b0;
      end else if (pmp_lsu_grant) begin
        arb_pmp_chk_vld       <= 1'b1;
        arb_pmp_chk_addr      <= lsu_pmp_addr;
        arb_pmp_chk_src       <= 1'b1;
        arb_pmp_chk_write     <= lsu_pmp_write;
        arb_pmp_chk_mach_mode <= lsu_pmp_machine_mode;
        chk_first_reg         <= lsu_pmp_cross;
        chk_second_reg        <= 1'b0;
        addr2_reg             <= lsu_pmp_addr2;
      end else begin
        arb_pmp_chk_vld <= 1'b0;
        chk_first_reg   <= 1'b0;
        chk_second_reg  <= 1'b0;
      end

      if (arb_pmp_chk_vld && chk_first_reg) begin
        sticky_deny_reg <= pmp_arb_deny;
      end

      pmp_ifu_rsp_vld  <= ifu_rsp_vld_next;
      pmp_ifu_rsp_deny <= ifu_rsp_vld_next && pmp_arb_deny;
      pmp_lsu_rsp_vld  <= lsu_rsp_vld_next;
      pmp_lsu_rsp_deny <= lsu_rsp_vld_next &&
                          (pmp_arb_deny || (chk_second_reg && sticky_deny_reg));
    end
  end

endmodule

// File: tb/tb_pa_pmp_chk_arb.sv
// Directed bench for pa_pmp_chk_arb: every cycle inputs are driven 1 time
// unit after the rising edge and outputs are checked 1 unit later.
module tb_pa_pmp_chk_arb;

  localparam int ADDR_W = 32;

  logic              forever_cpuclk = 1'b0;
  logic              cpurst;
  logic              ifu_pmp_req;
  logic [ADDR_W-1:0] ifu_pmp_addr;
  logic              ifu_pmp_machine_mode;
  logic              lsu_pmp_req;
  logic [ADDR_W-1:0] lsu_pmp_addr;
  logic [ADDR_W-1:0] lsu_pmp_addr2;
  logic              lsu_pmp_cross;
  logic              lsu_pmp_write;
  logic              lsu_pmp_machine_mode;
  logic              csr_pmp_busy;
  logic              ifu_pmp_flush;
  logic              pmp_arb_deny;
  logic              arb_pmp_chk_vld;
  logic [ADDR_W-1:0] arb_pmp_chk_addr;
  logic              arb_pmp_chk_src;
  logic              arb_pmp_chk_write;
  logic              arb_pmp_chk_mach_mode;
  logic              pmp_ifu_grant;
  logic              pmp_lsu_grant;
  logic              pmp_ifu_rsp_vld;
  logic              pmp_ifu_rsp_deny;
  logic              pmp_lsu_rsp_vld;
  logic              pmp_lsu_rsp_deny;

  int n_checks = 0;
  int n_errors = 0;

  pa_pmp_chk_arb #(.STARVE_MAX(4), .ADDR_W(ADDR_W)) dut (
    .forever_cpuclk        (forever_cpuclk),
    .cpurst                (cpurst),
    .ifu_pmp_req           (ifu_pmp_req),
    .ifu_pmp_addr          (ifu_pmp_addr),
    .ifu_pmp_machine_mode  (ifu_pmp_machine_mode),
    .lsu_pmp_req           (lsu_pmp_req),
    .lsu_pmp_addr          (lsu_pmp_addr),
    .lsu_pmp_addr2         (lsu_pmp_addr2),
    .lsu_pmp_cross         (lsu_pmp_cross),
    .lsu_pmp_write         (lsu_pmp_write),
    .lsu_pmp_machine_mode  (lsu_pmp_machine_mode),
    .csr_pmp_busy          (csr_pmp_busy),
    .ifu_pmp_flush         (ifu_pmp_flush),
    .pmp_arb_deny          (pmp_arb_deny),
    .arb_pmp_chk_vld       (arb_pmp_chk_vld),
    .arb_pmp_chk_addr      (arb_pmp_chk_addr),
    .arb_pmp_chk_src       (arb_pmp_chk_src),
    .arb_pmp_chk_write     (arb_pmp_chk_write),
    .arb_pmp_chk_mach_mode (arb_pmp_chk_mach_mode),
    .pmp_ifu_grant         (pmp_ifu_grant),
    .pmp_lsu_grant         (pmp_lsu_grant),
    .pmp_ifu_rsp_vld       (pmp_ifu_rsp_vld),
    .pmp_ifu_rsp_deny      (pmp_ifu_rsp_deny),
    .pmp_lsu_rsp_vld       (pmp_lsu_rsp_vld),
    .pmp_lsu_rsp_deny      (pmp_lsu_rsp_deny)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s value=%0h", tag, got);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic step();
    @(posedge forever_cpuclk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {22'd0, arb_pmp_chk_vld, arb_pmp_chk_addr, arb_pmp_chk_src,
            arb_pmp_chk_write, arb_pmp_chk_mach_mode, pmp_ifu_grant,
            pmp_lsu_grant, pmp_ifu_rsp_vld, pmp_ifu_rsp_deny,
            pmp_lsu_rsp_vld, pmp_lsu_rsp_deny};
  endfunction

  logic [5:0] exp_ifu_pat;
  logic [5:0] exp_lsu_pat;

  initial begin
    cpurst = 1'b1;
    ifu_pmp_req = 0; ifu_pmp_addr = '0; ifu_pmp_machine_mode = 0;
    lsu_pmp_req = 0; lsu_pmp_addr = '0; lsu_pmp_addr2 = '0;
    lsu_pmp_cross = 0; lsu_pmp_write = 0; lsu_pmp_machine_mode = 0;
    csr_pmp_busy = 0; ifu_pmp_flush = 0; pmp_arb_deny = 0;
    step(); step();
    chk("reset_outs", all_outs(), 64'd0);
    cpurst = 1'b0;

    // LSU single check, deny=1.
    lsu_pmp_req = 1; lsu_pmp_addr = 32'h2000_0000; lsu_pmp_write = 1;
    lsu_pmp_machine_mode = 1;
    #1;
    chk("t1_lsu_grant", pmp_lsu_grant, 1);
    chk("t1_ifu_grant", pmp_ifu_grant, 0);
    step();
    lsu_pmp_req = 0; pmp_arb_deny = 1;
    #1;
    chk("t1_chk_vld", arb_pmp_chk_vld, 1);
    chk("t1_chk_src", arb_pmp_chk_src, 1);
    chk("t1_chk_addr", arb_pmp_chk_addr, 64'h2000_0000);
    chk("t1_chk_write", arb_pmp_chk_write, 1);
    chk("t1_chk_mode", arb_pmp_chk_mach_mode, 1);
    chk("t1_rsp_early", pmp_lsu_rsp_vld, 0);
    step();
    pmp_arb_deny = 0; lsu_pmp_write = 0; lsu_pmp_machine_mode = 0;
    #1;
    chk("t1_rsp_vld", pmp_lsu_rsp_vld, 1);
    chk("t1_rsp_deny", pmp_lsu_rsp_deny, 1);
    chk("t1_chk_idle", arb_pmp_chk_vld, 0);
    step();

    // Starvation: both request continuously; IFU wins the 5th cycle.
    ifu_pmp_req = 1; ifu_pmp_addr = 32'h0000_0400; lsu_pmp_req = 1;
    lsu_pmp_addr = 32'h3000_0000;
    exp_ifu_pat = 6'b010000;
    exp_lsu_pat = 6'b101111;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("t2_ifu_grant_c%0d", i), pmp_ifu_grant, 64'(exp_ifu_pat[i]));
      chk($sformatf("t2_lsu_grant_c%0d", i), pmp_lsu_grant, 64'(exp_lsu_pat[i]));
      step();
    end
    ifu_pmp_req = 0; lsu_pmp_req = 0;
    step(); step();

    // LSU cross: deny 1 on first half, 0 on second.
    lsu_pmp_req = 1; lsu_pmp_cross = 1; lsu_pmp_addr = 32'h0000_0FFC;
    lsu_pmp_addr2 = 32'h0000_1000;
    #1;
    chk("t3_lsu_grant", pmp_lsu_grant, 1);
    step();
    lsu_pmp_req = 0; lsu_pmp_cross = 0; ifu_pmp_req = 1;
    ifu_pmp_addr = 32'h0000_0800; pmp_arb_deny = 1;
    #1;
    chk("t3_chk1_vld", arb_pmp_chk_vld, 1);
    chk("t3_chk1_addr", arb_pmp_chk_addr, 64'h0FFC);
    chk("t3_no_grant_ifu", pmp_ifu_grant, 0);
    step();
    pmp_arb_deny = 0;
    #1;
    chk("t3_chk2_vld", arb_pmp_chk_vld, 1);
    chk("t3_chk2_addr", arb_pmp_chk_addr, 64'h1000);
    chk("t3_chk2_src", arb_pmp_chk_src, 1);
    chk("t3_rsp_early", pmp_lsu_rsp_vld, 0);
    chk("t3_ifu_grant_t2", pmp_ifu_grant, 1);
    step();
    ifu_pmp_req = 0;
    #1;
    chk("t3_rsp_vld", pmp_lsu_rsp_vld, 1);
    chk("t3_rsp_deny", pmp_lsu_rsp_deny, 1);
    chk("t3_ifu_chk_src", arb_pmp_chk_src, 0);
    step();
    #1;
    chk("t3_ifu_rsp_vld", pmp_ifu_rsp_vld, 1);
    chk("t3_ifu_rsp_deny", pmp_ifu_rsp_deny, 0);
    step();

    // Flush kills an IFU check in the slot; LSU granted during flush survives.
    ifu_pmp_req = 1; ifu_pmp_addr = 32'h0000_0100;
    #1;
    chk("t4_ifu_grant", pmp_ifu_grant, 1);
    step();
    ifu_pmp_req = 0; lsu_pmp_req = 1; lsu_pmp_addr = 32'h4000_0000;
    ifu_pmp_flush = 1; pmp_arb_deny = 1;
    #1;
    chk("t4_lsu_grant", pmp_lsu_grant, 1);
    chk("t4_ifu_in_slot", arb_pmp_chk_src, 0);
    step();
    ifu_pmp_flush = 0; lsu_pmp_req = 0; pmp_arb_deny = 0;
    #1;
    chk("t4_ifu_rsp_killed", pmp_ifu_rsp_vld, 0);
    chk("t4_lsu_in_slot", arb_pmp_chk_src, 1);
    step();
    #1;
    chk("t4_lsu_rsp_vld", pmp_lsu_rsp_vld, 1);
    chk("t4_lsu_rsp_deny", pmp_lsu_rsp_deny, 0);
    // IFU grant in a flush cycle is not killed.
    ifu_pmp_req = 1; ifu_pmp_flush = 1; ifu_pmp_addr = 32'h0000_0200;
    #1;
    chk("t4_ifu_grant_flush", pmp_ifu_grant, 1);
    step();
    ifu_pmp_req = 0; ifu_pmp_flush = 0; pmp_arb_deny = 1;
    step();
    pmp_arb_deny = 0;
    #1;
    chk("t4_ifu_rsp_vld", pmp_ifu_rsp_vld, 1);
    chk("t4_ifu_rsp_deny", pmp_ifu_rsp_deny, 1);
    step();

    // csr busy: starvation count holds while grants are blocked.
    ifu_pmp_req = 1; lsu_pmp_req = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("t5_pre_lsu_c%0d", i), pmp_lsu_grant, 1);
      step();
    end
    csr_pmp_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t5_busy_grants_c%0d", i), {pmp_ifu_grant, pmp_lsu_grant}, 0);
      step();
    end
    csr_pmp_busy = 0;
    exp_ifu_pat = 6'b000100;
    exp_lsu_pat = 6'b000011;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t5_post_ifu_c%0d", i), pmp_ifu_grant, 64'(exp_ifu_pat[i]));
      chk($sformatf("t5_post_lsu_c%0d", i), pmp_lsu_grant, 64'(exp_lsu_pat[i]));
      step();
    end
    ifu_pmp_req = 0; lsu_pmp_req = 0;
    step(); step();

    // Reset in the middle of a cross split.
    lsu_pmp_req = 1; lsu_pmp_cross = 1; lsu_pmp_addr = 32'h0000_1FFC;
    lsu_pmp_addr2 = 32'h0000_2000;
    #1;
    chk("t6_lsu_grant", pmp_lsu_grant, 1);
    step();
    lsu_pmp_req = 0; lsu_pmp_cross = 0; pmp_arb_deny = 1;
    step();
    cpurst = 1;
    step();
    cpurst = 0; pmp_arb_deny = 0;
    #1;
    chk("t6_outs_zero", all_outs(), 64'd0);
    lsu_pmp_req = 1;
    #1;
    chk("t6_idle_grant", pmp_lsu_grant, 1);
    step();
    lsu_pmp_req = 0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
